// File: rtl/vend_seq_ctrl.sv
// Vending transaction sequencer: item select, coin collection, vend, then change or refund.
// All outputs are registered; one vend pulse and at most one payout pulse per transaction.
module vend_seq_ctrl #(
    parameter int CW      = 4,
    parameter int PRICE0  = 4,
    parameter int PRICE1  = 5,
    parameter int PRICE2  = 6,
    parameter int PRICE3  = 7,
    parameter int TIMEOUT = 200
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic [1:0]    Coin,
    input  logic [1:0]    Sel,
    input  logic          Sel_vld,
    input  logic          Cancel,
    output logic [CW-1:0] Credit,
    output logic          Busy,
    output logic          Coin_rej,
    output logic          Vend,
    output logic [1:0]    Item,
    output logic [CW-1:0] Change,
    output logic          Change_vld
);

    typedef enum logic [2:0] {IDLE, COLLECT, VEND, CHANGE, REFUND} state_t;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] price;
    logic [15:0]   timer;
    logic [CW:0]   sum;
    logic          coin_hit;

    // Sum carries one extra bit so that an overflowing coin shows up as sum[CW].
    assign sum      = {1'b0, Credit} + {{(CW-1){1'b0}}, Coin};
    assign coin_hit = (Coin != 2'b00);

    function automatic logic [CW-1:0] price_of(input logic [1:0] idx);
        case (idx)
            2'd0:    price_of = CW'(PRICE0);
            2'd1:    price_of = CW'(PRICE1);
            2'd2:    price_of = CW'(PRICE2);
            default: price_of = CW'(PRICE3);
        endcase
    endfunction

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state      <= IDLE;
            Credit     <= '0;
            price      <= '0;
            timer      <= '0;
            Busy       <= 1'b0;
            Coin_rej   <= 1'b0;
            Vend       <= 1'b0;
            Item       <= 2'b00;
            Change     <= '0;
            Change_vld <= 1'b0;
        end else begin
            Vend       <= 1'b0;
            Change_vld <= 1'b0;
            Coin_rej   <= 1'b0;
            case (state)
                IDLE: begin
                    Credit   <= '0;
                    Coin_rej <= coin_hit;
                    if (Sel_vld) begin
                        Item  <= Sel;
                        price <= price_of(Sel);
                        timer <= '0;
                        Busy  <= 1'b1;
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (Cancel) begin
                        Coin_rej   <= coin_hit;
                        Change     <= Credit;
                        Change_vld <= (Credit != '0);
                        state      <= REFUND;
                    end else if (Credit >= price) begin
                        Coin_rej <= coin_hit;
                        Vend     <= 1'b1;
                        state    <= VEND;
                    end else if (coin_hit) begin
                        if (sum[CW]) begin
                            Coin_rej <= 1'b1;
                        end else begin
                            Credit <= sum[CW-1:0];
                            timer  <= '0;
                            if (sum[CW-1:0] >= price) begin
                                Vend  <= 1'b1;
                                state <= VEND;
                            end
                        end
                    end else if (timer == TIMER_LAST) begin
                        Change     <= Credit;
                        Change_vld <= (Credit != '0);
                        state      <= REFUND;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                VEND: begin
                    Coin_rej <= coin_hit;
                    if (Credit > price) begin
                        Change     <= Credit - price;
                        Change_vld <= 1'b1;
                        state      <= CHANGE;
                    end else begin
                        Credit <= '0;
                        Busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                CHANGE, REFUND: begin
                    Coin_rej <= coin_hit;
                    Credit   <= '0;
                    Busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    Credit <= '0;
                    Busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
